// File: rtl/add_arbiter_pkg.sv
// Shared types and widths for the two-requester arbitrated adder.
// The state encoding is fixed so that res_valid is simply the state bit.
package add_arbiter_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        RESULT = 1'b1
    } state_t;

endpackage

// File: rtl/add_arbiter_fadder32.sv
// 32-bit full adder: {cout,sum} = a + b + cin, carry out of bit 31 kept.
module fadder32
    import add_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    output logic [DATA_W-1:0] sum,
    output logic              cout
);

    logic [DATA_W:0] full_sum;

    assign full_sum = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
    assign sum      = full_sum[DATA_W-1:0];
    assign cout     = full_sum[DATA_W];

endmodule

// File: rtl/add_arbiter.sv
// Two requesters share one adder; one registered result slot with valid/ready
// handshake, round-robin or fixed-priority grant, and an accepted-result counter.
module add_arbiter
    import add_arbiter_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic [DATA_W-1:0] a0,
    input  logic [DATA_W-1:0] b0,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] b1,
    input  logic              cin0,
    input  logic              cin1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_id,
    output logic [DATA_W-1:0] res_sum,
    output logic              res_cout,
    output logic [CNT_W-1:0]  done_cnt
);

    state_t             state_reg, state_next;
    logic               last_id_reg;
    logic               id_reg;
    logic [DATA_W-1:0]  sum_reg;
    logic               cout_reg;
    logic [CNT_W-1:0]   done_cnt_reg;

    logic               slot_free;
    logic               grant;
    logic               sel;
    logic [DATA_W-1:0]  op_a, op_b;
    logic               op_cin;
    logic [DATA_W-1:0]  add_sum;
    logic               add_cout;

    // The slot is free when empty, or when its current result leaves this cycle.
    assign slot_free = (state_reg == IDLE) || res_ready;
    assign res_valid = (state_reg == RESULT);

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n && slot_free) begin
            if (req0 && req1) begin
                if (RR_EN && (last_id_reg == 1'b0))
                    gnt1 = 1'b1;
                else
                    gnt0 = 1'b1;
            end else if (req0) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign grant  = gnt0 | gnt1;
    assign sel    = gnt1;
    assign op_a   = sel ? a1   : a0;
    assign op_b   = sel ? b1   : b0;
    assign op_cin = sel ? cin1 : cin0;

    fadder32 u_fadder32 (
        .a    (op_a),
        .b    (op_b),
        .cin  (op_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        state_next = state_reg;
        if (grant)
            state_next = RESULT;
        else if ((state_reg == RESULT) && res_ready)
            state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            last_id_reg  <= 1'b1;
            id_reg       <= 1'b0;
            sum_reg      <= '0;
            cout_reg     <= 1'b0;
            done_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (grant) begin
                sum_reg     <= add_sum;
                cout_reg    <= add_cout;
                id_reg      <= sel;
                last_id_reg <= sel;
            end
            if (res_valid && res_ready)
                done_cnt_reg <= done_cnt_reg + CNT_W'(1);
        end
    end

    assign res_id   = id_reg;
    assign res_sum  = sum_reg;
    assign res_cout = cout_reg;
    assign done_cnt = done_cnt_reg;

endmodule

// File: tb/tb_add_arbiter.sv
// Directed bench for add_arbiter: stimulus pushes hand-computed results into a
// scoreboard queue; a monitor pops and compares on every accepted result.
module tb_add_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1;
    logic [31:0] a0, b0, a1, b1;
    logic        cin0, cin1;
    logic        gnt0, gnt1;
    logic        res_valid, res_ready;
    logic        res_id;
    logic [31:0] res_sum;
    logic        res_cout;
    logic [7:0]  done_cnt;

    logic        fp_gnt0, fp_gnt1, fp_res_valid, fp_res_id, fp_res_cout;
    logic        fp_ready;
    logic [31:0] fp_res_sum;
    logic [7:0]  fp_done_cnt;

    int checks = 0;
    int errors = 0;

    // Entry: {id, cout, sum}
    logic [33:0] sb[$];

    always #5 clk = ~clk;

    add_arbiter #(.RR_EN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .cin0(cin0), .cin1(cin1),
        .gnt0(gnt0), .gnt1(gnt1), .res_valid(res_valid), .res_ready(res_ready),
        .res_id(res_id), .res_sum(res_sum), .res_cout(res_cout), .done_cnt(done_cnt)
    );

    add_arbiter #(.RR_EN(1'b0)) u_fp (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .cin0(cin0), .cin1(cin1),
        .gnt0(fp_gnt0), .gnt1(fp_gnt1), .res_valid(fp_res_valid), .res_ready(fp_ready),
        .res_id(fp_res_id), .res_sum(fp_res_sum), .res_cout(fp_res_cout), .done_cnt(fp_done_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Raise one request, wait (bounded) for its grant, record the expected result.
    task automatic issue(input logic id, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic [32:0] exp);
        bit got = 0;
        if (id == 1'b0) begin
            a0 = a; b0 = b; cin0 = cin; req0 = 1'b1;
        end else begin
            a1 = a; b1 = b; cin1 = cin; req1 = 1'b1;
        end
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if ((id == 1'b0 && gnt0) || (id == 1'b1 && gnt1)) begin
                got = 1;
                sb.push_back({id, exp});
            end
        end
        check("issue_grant", {63'b0, got}, 64'd1);
        @(posedge clk); #1;
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    // Monitor: one line per accepted result, compared against the scoreboard.
    initial begin
        logic [33:0] exp;
        forever begin
            @(negedge clk);
            check("gnt_onehot", {63'b0, gnt0 & gnt1}, 64'd0);
            if (rst_n && res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got id=%0d sum=%h cout=%b expected none",
                             res_id, res_sum, res_cout);
                end else begin
                    exp = sb.pop_front();
                    check("result", {30'b0, res_id, res_cout, res_sum}, {30'b0, exp});
                    $display("result id=%0d sum=%h cout=%b done_cnt=%0d",
                             res_id, res_sum, res_cout, done_cnt);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req0 = 1'b1; req1 = 1'b0;
        a0 = 32'd9; b0 = 32'd4; cin0 = 1'b0;
        a1 = '0; b1 = '0; cin1 = 1'b0;
        res_ready = 1'b1;
        fp_ready  = 1'b1;

        // Reset with req0 held high: no grant, no result, all state zero.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("rst_gnt0", {63'b0, gnt0}, 64'd0);
            check("rst_valid", {63'b0, res_valid}, 64'd0);
            check("rst_state", {23'b0, res_id, res_cout, res_sum, done_cnt}, 64'd0);
            @(posedge clk);
        end
        #1 rst_n = 1'b1;

        // Single add 9+4: grant in the first cycle after release, result next cycle.
        @(negedge clk);
        check("first_gnt0", {63'b0, gnt0}, 64'd1);
        sb.push_back({1'b0, 33'h0_0000_000D});
        @(posedge clk); #1;
        req0 = 1'b0;
        @(negedge clk);
        check("latency_valid", {63'b0, res_valid}, 64'd1);
        @(posedge clk); #1;

        // Overflow on requester 1.
        issue(1'b1, 32'hFFFF_FFFF, 32'd1, 1'b1, 33'h1_0000_0001);

        // Contention: round-robin 0,1,0,1; fixed priority always 0.
        a0 = 32'd10;  b0 = 32'd20;  cin0 = 1'b0;
        a1 = 32'd100; b1 = 32'd200; cin1 = 1'b1;
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rr_gnt", {62'b0, gnt1, gnt0}, (k % 2 == 0) ? 64'd1 : 64'd2);
            check("fp_gnt", {62'b0, fp_gnt1, fp_gnt0}, 64'd1);
            if (gnt0) sb.push_back({1'b0, 33'd30});
            if (gnt1) sb.push_back({1'b1, 33'd301});
            @(posedge clk); #1;
        end
        req0 = 1'b0; req1 = 1'b0;
        @(posedge clk); #1;

        // Backpressure: 7+8+1 held for 3 cycles while requester 1 waits.
        res_ready = 1'b0;
        issue(1'b0, 32'd7, 32'd8, 1'b1, 33'd16);
        a1 = 32'd5; b1 = 32'd6; cin1 = 1'b0; req1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_gnt1", {63'b0, gnt1}, 64'd0);
            check("bp_valid", {63'b0, res_valid}, 64'd1);
            check("bp_payload", {30'b0, res_id, res_cout, res_sum}, 64'd16);
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        @(negedge clk);
        check("bp_release_gnt1", {63'b0, gnt1}, 64'd1);
        if (gnt1) sb.push_back({1'b1, 33'd11});
        @(posedge clk); #1;
        req1 = 1'b0;
        @(negedge clk);
        check("bp_done_cnt", {56'b0, done_cnt}, 64'd7);
        @(posedge clk); #1;

        // Reset while a result is held: discarded and not counted.
        res_ready = 1'b0;
        issue(1'b0, 32'd1, 32'd2, 1'b0, 33'd3);
        rst_n = 1'b0;
        @(posedge clk); #1;
        sb.delete();
        @(negedge clk);
        check("rst_result_valid", {63'b0, res_valid}, 64'd0);
        check("rst_result_cnt", {56'b0, done_cnt}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        res_ready = 1'b1;

        // 256 back-to-back results wrap the counter to 0.
        a0 = 32'd1; b0 = 32'd1; cin0 = 1'b0; req0 = 1'b1;
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            check("b2b_gnt0", {63'b0, gnt0}, 64'd1);
            if (gnt0) sb.push_back({1'b0, 33'd2});
            @(posedge clk); #1;
        end
        req0 = 1'b0;
        for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
        check("drain", 64'(sb.size()), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("wrap_done_cnt", {56'b0, done_cnt}, 64'd0);
        check("wrap_idle", {63'b0, res_valid}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/add_arbiter.md
ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 SHALL have parameter RR_EN, default 1: 1 = round-robin grant between requesters; 0 = fixed priority, requester 0 wins.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-004 SHALL have ports req0/req1, input, 1 each, requester wants one add.
REQ-005 SHALL have ports a0/b0 and a1/b1, input, 32 each, requester operands.
REQ-006 SHALL have ports cin0/cin1, input, 1 each, requester carry-in.
REQ-007 SHALL have ports gnt0/gnt1, output, 1 each, combinational acceptance of that requester's operands this cycle.
REQ-008 SHALL have port res_valid, output, 1, result payload valid.
REQ-009 SHALL have port res_ready, input, 1, consumer accepts the result.
REQ-010 SHALL have port res_id, output, 1, index of the requester that owns the result.
REQ-011 SHALL have ports res_sum, output, 32, and res_cout, output, 1, registered adder result.
REQ-012 SHALL have port done_cnt, output, 8, count of results accepted by the consumer.

Function
REQ-013 SHALL implement two states: IDLE (no result held) and RESULT (res_valid=1).
REQ-014 SHALL define "slot free" as state IDLE, or state RESULT with res_ready=1.
REQ-015 SHALL, when slot free and at least one req is high, assert exactly one gnt in that cycle; never both.
REQ-016 SHALL never assert any gnt when the slot is not free.
REQ-017 SHALL resolve req0=req1=1 with RR_EN=1 against last_id: grant the requester not equal to last_id, then set last_id to the granted index.
REQ-018 SHALL resolve req0=req1=1 with RR_EN=0 by granting requester 0.
REQ-019 SHALL, on a granted edge, register {res_cout,res_sum} = a+b+cin of the granted requester, with the 33-bit result taken modulo 2^33, set res_id, and enter or remain in RESULT.
REQ-020 SHALL give latency of exactly 1 cycle: res_valid is high in the cycle after the gnt.
REQ-021 SHALL hold res_sum, res_cout and res_id stable while res_valid=1 and res_ready=0.
REQ-022 SHALL, on res_valid&&res_ready with no grant, return to IDLE with res_valid=0 next cycle.
REQ-023 SHALL support back-to-back operation: result acceptance plus a new grant in the same cycle keeps RESULT, for throughput 1 op/cycle.
REQ-024 SHALL increment done_cnt on each res_valid&&res_ready, wrapping 255->0.
REQ-025 SHALL ignore res_ready while in IDLE.
REQ-026 SHALL place no stability requirement on a requester's operands after its gnt cycle; before gnt, the requester holds req and operands stable.

Reset
REQ-027 SHALL, while rst_n=0 at a clock edge, set state=IDLE, res_valid=0, res_sum=0, res_cout=0, res_id=0, done_cnt=0 and last_id=1.
REQ-028 SHALL force gnt0=gnt1=0 while rst_n=0, regardless of req.
REQ-029 SHALL discard a pending result on reset mid-RESULT, without counting it.

Structure
REQ-030 SHALL place state encodings (IDLE=0, RESULT=1) and the widths (DATA_W=32, CNT_W=8) in shared package add_arbiter_pkg.
REQ-031 SHALL instantiate the existing 32-bit full adder fadder32 once, fed by a 2:1 operand mux selected by the grant, as its only sub-module.

Verification
REQ-032 SHALL cover reset: rst_n=0 for 2 cycles with req0=1 -> gnt0=0 and res_valid=0 throughout; gnt0=1 in the first cycle after release.
REQ-033 SHALL cover a single add: req0 with a0=9, b0=4, cin0=0 -> gnt0 at cycle T; at T+1 res_valid=1, res_sum=13, res_cout=0, res_id=0.
REQ-034 SHALL cover overflow: req1 with a1=32'hFFFFFFFF, b1=1, cin1=1 -> res_sum=1, res_cout=1, res_id=1.
REQ-035 SHALL cover contention: req0=req1 held high, res_ready=1, RR_EN=1 -> grants 0,1,0,1 on consecutive cycles; with RR_EN=0 -> always gnt0.
REQ-036 SHALL cover backpressure: res_ready=0 for 3 cycles with req1 pending -> payload unchanged and gnt1=0; then res_ready=1 -> done_cnt+1 and gnt1 in that same cycle.
REQ-037 SHALL cover reset in RESULT and counter wrap: rst_n=0 during RESULT -> res_valid=0 next cycle and done_cnt=0; 256 accepted results -> done_cnt=0.
